// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Turns parallel words into a serial bit stream for the downstream sequence
//   detector. The block has a one-entry holding register so that a word offered
//   while another is being shifted out follows it with no idle cycle.
//
//   Optional feature (compile-time macro SERIALIZER_PARITY_EN):
//     when defined, every word is followed by one even-parity bit, making each
//     word WIDTH+1 serial cycles long. When undefined, the parity state and its
//     logic are not built and each word takes exactly WIDTH cycles.
//
// Parameters
//   WIDTH      bits per parallel word (2..32)
//   MSB_FIRST  1: MSB is sent first, 0: LSB is sent first
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_valid    in_data holds a word to be accepted
//   in_data     parallel word (WIDTH bits)
//   in_ready    a word can be accepted this cycle (holding register empty)
//   bit_out     serial bit (registered)
//   bit_valid   bit_out carries a payload or parity bit this cycle
//   busy        FSM not idle, or holding register full
//   word_count  number of completely serialized words, modulo 2^16
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic [15:0]      word_count
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      word_count_q;
  logic             bit_out_q;
  logic             bit_valid_q;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q;
`endif

  logic             accept;
  logic             last_bit;
  logic             word_end;
  logic             load_en;
  logic             hold_wr;
  logic [WIDTH-1:0] load_word_d;
  logic [WIDTH-1:0] shreg_d;

  // Bit that goes on the wire first for a given shift-register content.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Gating with rst keeps in_ready low while reset is held and lets it rise
  // as soon as reset is released.
  assign in_ready = rst & ~hold_full_q;
  assign accept   = in_valid & in_ready;
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);

`ifdef SERIALIZER_PARITY_EN
  assign word_end = (state_q == PARITY);
`else
  assign word_end = last_bit;
`endif

  // The held word has priority; in_ready is low whenever it is present, so a
  // same-edge acceptance can only happen when the holding register is empty.
  assign load_word_d = hold_full_q ? hold_q : in_data;
  assign load_en     = ((state_q == IDLE) && accept) || (word_end && (hold_full_q || accept));
  // Words arriving mid-word are parked; at the word boundary they bypass the
  // holding register and go straight into the shifter.
  assign hold_wr     = accept && (state_q != IDLE) && !word_end;

  assign shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      cnt_q        <= '0;
      word_count_q <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      if (hold_wr) begin
        hold_q      <= in_data;
        hold_full_q <= 1'b1;
      end else if (word_end && hold_full_q) begin
        hold_full_q <= 1'b0;
      end

      if (word_end) begin
        word_count_q <= word_count_q + 16'd1;
      end

      if (load_en) begin
        state_q     <= SHIFT;
        shreg_q     <= load_word_d;
        cnt_q       <= '0;
        bit_out_q   <= first_bit(load_word_d);
        bit_valid_q <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
        parity_q    <= ^load_word_d;
`endif
      end else if (word_end) begin
        state_q     <= IDLE;
        shreg_q     <= '0;
        cnt_q       <= '0;
        bit_out_q   <= 1'b0;
        bit_valid_q <= 1'b0;
      end else if (state_q == SHIFT) begin
`ifdef SERIALIZER_PARITY_EN
        if (last_bit) begin
          state_q   <= PARITY;
          bit_out_q <= parity_q;
        end else begin
          cnt_q     <= cnt_q + CNT_W'(1);
          shreg_q   <= shreg_d;
          bit_out_q <= first_bit(shreg_d);
        end
`else
        cnt_q     <= cnt_q + CNT_W'(1);
        shreg_q   <= shreg_d;
        bit_out_q <= first_bit(shreg_d);
`endif
      end
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = (state_q != IDLE) | hold_full_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//   Two instances share clock and reset: dut (MSB first) and dut_l (LSB first),
//   both WIDTH=8. Directed table vectors, hand-written reset/back-to-back/wrap
//   sequences, and a randomized run against a bit-queue reference model.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int BPW = 9;
`else
  localparam int BPW = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_valid_l = 1'b0;
  logic [7:0]  in_data = '0, in_data_l = '0;
  logic        in_ready, in_ready_l;
  logic        bit_out, bit_out_l;
  logic        bit_valid, bit_valid_l;
  logic        busy, busy_l;
  logic [15:0] word_count, word_count_l;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .busy(busy), .word_count(word_count)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_data(in_data_l),
    .in_ready(in_ready_l), .bit_out(bit_out_l), .bit_valid(bit_valid_l),
    .busy(busy_l), .word_count(word_count_l)
  );

  int nvec = 0;
  int nerr = 0;
  logic [15:0] wc_m = '0;
  logic [15:0] wc_l = '0;

  // Reference model for dut: queue of bits still to be shown on the wire.
  bit          mq[$];
  bit          m_cur_v = 1'b0;
  bit          m_cur_b = 1'b0;
  int          m_popped = 0;
  logic [15:0] m_base = '0;

  typedef struct {
    string      nm;
    bit         lsb;
    logic [7:0] d;
    logic [8:0] exp;   // bits in wire order from [8] down, parity in [0]
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_sync(input logic [15:0] base);
    mq.delete();
    m_cur_v  = 1'b0;
    m_cur_b  = 1'b0;
    m_popped = 0;
    m_base   = base;
  endtask

  // Called at a negedge: check dut against the model, drive inputs, advance.
  task automatic model_cycle(input bit v, input logic [7:0] d, output bit acc);
    logic [15:0] exp_wc;
    exp_wc = m_base + 16'((m_popped - int'(m_cur_v)) / BPW);
    chk("m_valid", bit_valid, m_cur_v);
    chk("m_bit", bit_out, m_cur_b);
    chk("m_ready", in_ready, mq.size() < BPW);
    chk("m_busy", busy, m_cur_v || (mq.size() >= BPW));
    chk("m_wcount", word_count, exp_wc);
    in_valid = v;
    in_data  = d;
    acc = v && (mq.size() < BPW);
    if (acc) begin
      for (int i = 0; i < 8; i++) mq.push_back(d[7-i]);
      if (BPW == 9) mq.push_back(^d);
    end
    if (mq.size() > 0) begin
      m_cur_b = mq.pop_front();
      m_cur_v = 1'b1;
      m_popped++;
    end else begin
      m_cur_v = 1'b0;
      m_cur_b = 1'b0;
    end
    step();
  endtask

  task automatic send_check(input string nm, input bit lsb, input logic [7:0] d,
                            input logic [8:0] exp);
    if (lsb) begin in_valid_l = 1'b1; in_data_l = d; end
    else     begin in_valid   = 1'b1; in_data   = d; end
    step();
    in_valid   = 1'b0;
    in_valid_l = 1'b0;
    in_data    = 8'hFF;   // later in_data changes must not disturb the word
    in_data_l  = 8'hFF;
    for (int k = 0; k < BPW; k++) begin
      chk({nm, "_valid"}, lsb ? bit_valid_l : bit_valid, 1);
      chk({nm, "_bit"},   lsb ? bit_out_l   : bit_out,   exp[8-k]);
      step();
    end
    chk({nm, "_end_valid"}, lsb ? bit_valid_l : bit_valid, 0);
    chk({nm, "_end_bit"},   lsb ? bit_out_l   : bit_out,   0);
    if (lsb) begin wc_l = wc_l + 16'd1; chk({nm, "_wcount"}, word_count_l, wc_l); end
    else     begin wc_m = wc_m + 16'd1; chk({nm, "_wcount"}, word_count,   wc_m); end
  endtask

  initial begin
    bit acc;
    int idx, run, maxrun;
    logic [7:0] w[3];

    tbl[0] = '{"msb_b2",  1'b0, 8'b1011_0010, 9'b1011_0010_0};
    tbl[1] = '{"lsb_01",  1'b1, 8'h01,        9'b1000_0000_1};
    tbl[2] = '{"msb_07",  1'b0, 8'h07,        9'b0000_0111_1};
    tbl[3] = '{"msb_03",  1'b0, 8'h03,        9'b0000_0011_0};
    tbl[4] = '{"lsb_c1",  1'b1, 8'hC1,        9'b1000_0011_1};

    // Reset state, with in_valid asserted to show it is ignored
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst_ready",  in_ready, 0);
    chk("rst_bit",    bit_out, 0);
    chk("rst_valid",  bit_valid, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_wcount", word_count, 0);
    chk("rst_ready_l", in_ready_l, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("post_rst_ready",   in_ready, 1);
    chk("post_rst_ready_l", in_ready_l, 1);
    @(negedge clk);

    for (int i = 0; i < 5; i++) send_check(tbl[i].nm, tbl[i].lsb, tbl[i].d, tbl[i].exp);

    // Back-to-back: three words with in_valid held high
    model_sync(wc_m);
    w[0] = 8'hC3; w[1] = 8'h5A; w[2] = 8'h96;
    idx = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 40; c++) begin
      if (bit_valid) run++; else run = 0;
      if (run > maxrun) maxrun = run;
      if (c == 4) chk("b2b_ready_low", in_ready, 0);
      model_cycle(idx < 3, (idx < 3) ? w[idx] : 8'h00, acc);
      if (acc) idx++;
    end
    chk("b2b_run", maxrun, 3 * BPW);
    wc_m = wc_m + 16'd3;
    chk("b2b_wcount", word_count, wc_m);

    // Randomized traffic against the model
    model_sync(wc_m);
    for (int c = 0; c < 600; c++) model_cycle($urandom_range(0, 3) != 0, 8'($urandom), acc);
    for (int c = 0; c < 3 * BPW; c++) model_cycle(1'b0, 8'h00, acc);
    wc_m = m_base + 16'(m_popped / BPW);

    // Reset asserted while bit 4 of a word is on the wire
    in_valid = 1'b1; in_data = 8'hB2;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mid_valid", bit_valid, 1);
    chk("mid_bit4",  bit_out, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_ready",    in_ready, 0);
    chk("arst_bit",      bit_out, 0);
    chk("arst_valid",    bit_valid, 0);
    chk("arst_busy",     busy, 0);
    chk("arst_wcount",   word_count, 0);
    chk("arst_wcount_l", word_count_l, 0);
    step();
    chk("arst_hold_valid", bit_valid, 0);
    rst = 1'b1;
    #1;
    chk("arst_rel_ready", in_ready, 1);
    wc_m = '0; wc_l = '0;
    @(negedge clk);
    send_check("after_rst", 1'b0, 8'h5A, 9'b0101_1010_0);

    // word_count wrap from FFFF
    @(negedge clk);
    force dut.word_count_q = 16'hFFFF;
    step();
    release dut.word_count_q;
    step();
    chk("wrap_preload", word_count, 16'hFFFF);
    model_sync(16'hFFFF);
    model_cycle(1'b1, 8'h3C, acc);
    for (int c = 0; c < BPW + 2; c++) model_cycle(1'b0, 8'h00, acc);
    chk("wrap_zero", word_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
